// File: rtl/hazard_scoreboard_pkg.sv
// Shared ISA-level constants for the hazard scoreboard: register index
// width, the hard-wired zero register and the producer latency classes.
package hazard_scoreboard_pkg;

  // Architectural register index width (32 registers).
  localparam int ISA_REG_W = 5;

  // x0 is hard-wired to zero and never creates a dependency.
  localparam int X0_IDX = 0;

  // Producer latency classes, in cycles until the result is forwardable.
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

  // True when a register index names a tracked (non-x0) register.
  function automatic logic is_tracked(input int unsigned idx);
    return idx != X0_IDX;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One per-register countdown of the hazard scoreboard. It holds the number
// of cycles remaining until the pending producer's result can be forwarded.
module hazard_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             clear,
  output logic [LAT_W-1:0] cnt
);

  // Reset and redirect-clear dominate, then a fresh issue, else count down to zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-dependency hazard scoreboard. Tracks, per architectural register,
// how many cycles remain until an in-flight producer's result is
// forwardable, stalls IF/ID on RAW/WAW hazards, and on a taken redirect
// kills younger stages and forgets the counters they had set.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int REG_W       = ISA_REG_W,
  parameter int MAX_LAT     = 4,
  parameter int FLUSH_DEPTH = 1,
  localparam int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_W-1:0]       rs1_id_in,
  input  logic [REG_W-1:0]       rs2_id_in,
  input  logic                   rs1_used,
  input  logic                   rs2_used,
  input  logic [REG_W-1:0]       rd_id_in,
  input  logic                   rd_we,
  input  logic [LAT_W-1:0]       lat_id_in,
  input  logic                   branch_in,
  input  logic                   jump_in,
  output logic                   stall,
  output logic [FLUSH_DEPTH-1:0] flush_mask,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [15:0]            stall_cnt
);

  localparam logic [REG_W-1:0] X0 = REG_W'(X0_IDX);

  logic                flush;
  logic                issue;
  logic                issue_wr;
  logic                raw1;
  logic                raw2;
  logic                waw;
  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:1] load_vec;
  logic [NUM_REGS-1:1] kill_vec;

  // A taken redirect outranks everything else happening in ID this cycle.
  assign flush      = branch_in | jump_in;
  assign issue      = id_valid && !stall && !flush;
  assign issue_wr   = issue && rd_we && (rd_id_in != X0);
  assign flush_mask = {FLUSH_DEPTH{flush}};

  // x0 is never tracked; its counter reads as constant zero.
  assign cnt[0] = '0;

  // Issue decode: select which register counter loads the new latency.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    load_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      load_vec[r] = issue_wr && (rd_id_in == REG_W'(r));
    end
  end

  // Per-register countdowns, one entry for each tracked register.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .load     (load_vec[r]),
      .load_val (lat_id_in),
      .clear    (flush && kill_vec[r]),
      .cnt      (cnt[r])
    );
  end

  // Issue history: which registers the killed younger stages were about to write.
  if (FLUSH_DEPTH > 1) begin : g_hist
    typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
    } hist_t;

    hist_t hist [FLUSH_DEPTH-1];

    // Shift the issue record every cycle; a redirect wipes every entry.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int i = 0; i < FLUSH_DEPTH - 1; i++) begin
          hist[i] <= '0;
        end
      end else begin
        hist[0] <= '{valid: issue_wr, rd: rd_id_in};
        for (int i = 1; i < FLUSH_DEPTH - 1; i++) begin
          hist[i] <= hist[i-1];
        end
      end
    end

    // Mark every register named by a live history entry for clearing.
    always_comb begin
      kill_vec = '0;
      for (int i = 0; i < FLUSH_DEPTH - 1; i++) begin
        for (int r = 1; r < NUM_REGS; r++) begin
          if (hist[i].valid && (hist[i].rd == REG_W'(r))) begin
            kill_vec[r] = 1'b1;
          end
        end
      end
    end
  end else begin : g_no_hist
    // Only ID is killed; nothing issued earlier needs undoing.
    assign kill_vec = '0;
  end

  // Hazard detection against the currently pending counters.
  always_comb begin
    raw1  = rs1_used && (rs1_id_in != X0) && (cnt[rs1_id_in] != '0);
    raw2  = rs2_used && (rs2_id_in != X0) && (cnt[rs2_id_in] != '0);
    waw   = rd_we    && (rd_id_in  != X0) && (cnt[rd_id_in]  != '0);
    stall = id_valid && !flush && (raw1 || raw2 || waw);
  end

  // Busy view of the registered counters.
  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_mask[r] = is_tracked(r) && (cnt[r] != '0);
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, multi-cycle producers,
// x0 handling, redirect priority and history clearing, stall counter
// saturation and reset recovery.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NUM_REGS    = 32;
  localparam int REG_W       = 5;
  localparam int MAX_LAT     = 15;
  localparam int FLUSH_DEPTH = 2;
  localparam int LAT_W       = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   id_valid;
  logic [REG_W-1:0]       rs1_id_in;
  logic [REG_W-1:0]       rs2_id_in;
  logic                   rs1_used;
  logic                   rs2_used;
  logic [REG_W-1:0]       rd_id_in;
  logic                   rd_we;
  logic [LAT_W-1:0]       lat_id_in;
  logic                   branch_in;
  logic                   jump_in;
  logic                   stall;
  logic [FLUSH_DEPTH-1:0] flush_mask;
  logic [NUM_REGS-1:0]    busy_mask;
  logic [15:0]            stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard #(
    .NUM_REGS    (NUM_REGS),
    .REG_W       (REG_W),
    .MAX_LAT     (MAX_LAT),
    .FLUSH_DEPTH (FLUSH_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .rs1_id_in  (rs1_id_in),
    .rs2_id_in  (rs2_id_in),
    .rs1_used   (rs1_used),
    .rs2_used   (rs2_used),
    .rd_id_in   (rd_id_in),
    .rd_we      (rd_we),
    .lat_id_in  (lat_id_in),
    .branch_in  (branch_in),
    .jump_in    (jump_in),
    .stall      (stall),
    .flush_mask (flush_mask),
    .busy_mask  (busy_mask),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v,
                       input logic [REG_W-1:0] r1, input logic u1,
                       input logic [REG_W-1:0] r2, input logic u2,
                       input logic [REG_W-1:0] rd, input logic we,
                       input logic [LAT_W-1:0] lat);
    id_valid  = v;
    rs1_id_in = r1;
    rs1_used  = u1;
    rs2_id_in = r2;
    rs2_used  = u2;
    rd_id_in  = rd;
    rd_we     = we;
    lat_id_in = lat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0);
    branch_in = 1'b0;
    jump_in   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    settle();

    // Out of reset with idle inputs.
    check("reset_stall",     32'(stall),      32'd0);
    check("reset_flush",     32'(flush_mask), 32'd0);
    check("reset_busy",      busy_mask,       32'd0);
    check("reset_stall_cnt", 32'(stall_cnt),  32'd0);

    // Load to x5, then a reader of x5: exactly one stall cycle.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'(LAT_LOAD));
    settle();
    check("load_issue_stall", 32'(stall), 32'd0);
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 4'(LAT_ALU));
    settle();
    check("loaduse_stall", 32'(stall), 32'd1);
    check("loaduse_busy5", 32'(busy_mask[5]), 32'd1);
    step();
    settle();
    check("loaduse_release", 32'(stall), 32'd0);
    check("loaduse_busy5_clr", 32'(busy_mask[5]), 32'd0);
    check("loaduse_stall_cnt", 32'(stall_cnt), 32'd1);
    step();
    idle();
    settle();
    check("loaduse_busy_after", busy_mask, 32'd0);

    // Mul to x7 (lat 3), dependent reader via rs2: three stall cycles.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd3);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 4'd0);
    settle();
    check("mul_stall_c1", 32'(stall), 32'd1);
    step();
    settle();
    check("mul_stall_c2", 32'(stall), 32'd1);
    step();
    settle();
    check("mul_stall_c3", 32'(stall), 32'd1);
    step();
    settle();
    check("mul_release", 32'(stall), 32'd0);
    check("mul_stall_cnt", 32'(stall_cnt), 32'd4);
    step();

    // Same mul followed by an independent instruction: no stall.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd3);
    step();
    drive(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 4'd0);
    settle();
    check("indep_no_stall", 32'(stall), 32'd0);
    check("indep_busy7", 32'(busy_mask[7]), 32'd1);
    step();
    idle();
    step();
    step();
    settle();
    check("mul_drained_busy", busy_mask, 32'd0);

    // Everything on x0 with a long latency: never tracked.
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 4'd4);
    settle();
    check("x0_no_stall", 32'(stall), 32'd0);
    step();
    idle();
    settle();
    check("x0_busy", busy_mask, 32'd0);
    check("x0_stall_cnt", 32'(stall_cnt), 32'd4);

    // Writer of x9 issues, branch next cycle kills it and clears cnt[9].
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 4'd3);
    step();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 4'd3);
    branch_in = 1'b1;
    settle();
    check("branch_flush_mask", 32'(flush_mask), 32'd3);
    check("branch_no_stall", 32'(stall), 32'd0);
    check("branch_busy9", 32'(busy_mask[9]), 32'd1);
    step();
    branch_in = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 4'd0);
    settle();
    check("branch_mask_one_cycle", 32'(flush_mask), 32'd0);
    check("branch_cleared_busy", busy_mask, 32'd0);
    check("branch_reader_no_stall", 32'(stall), 32'd0);
    step();
    idle();

    // Stall condition plus jump: jump wins, ID instruction does not issue.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd3);
    step();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 4'd2);
    jump_in = 1'b1;
    settle();
    check("jump_no_stall", 32'(stall), 32'd0);
    check("jump_flush_mask", 32'(flush_mask), 32'd3);
    step();
    idle();
    settle();
    check("jump_busy", busy_mask, 32'd0);
    check("jump_stall_cnt", 32'(stall_cnt), 32'd4);

    // Self-dependent long-latency instruction held in ID: saturate stall_cnt.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 4'd15);
    for (int i = 0; i < 70000; i++) begin
      step();
    end
    settle();
    check("stall_cnt_saturated", 32'(stall_cnt), 32'h0000FFFF);

    // Reset mid-countdown clears everything at the next edge.
    rst = 1'b1;
    idle();
    step();
    settle();
    check("rst_stall",     32'(stall),      32'd0);
    check("rst_flush",     32'(flush_mask), 32'd0);
    check("rst_busy",      busy_mask,       32'd0);
    check("rst_stall_cnt", 32'(stall_cnt),  32'd0);
    rst = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 4'd0);
    settle();
    check("post_rst_reader_no_stall", 32'(stall), 32'd0);
    step();
    idle();
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
